axi_slave_mem: RTL

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

---
 rtl/axi_slave_mem_if.sv | 71 +++++++
 rtl/axi_slave_mem.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem_if.sv
// -----------------------------------------------------------------------------
// axi_slave_mem_if
//   Single-beat AXI4 subset bus seen by axi_slave_mem. It carries the five
//   channels (AW, W, B, AR, R), but not the clock or reset.
//   Modports:
//     slave  - used by the memory: it drives the readys on AW/W/AR and the
//              whole of B/R.
//     master - used by the requester: it drives the AW/W/AR payloads and
//              valids, plus b_ready and r_ready.
// -----------------------------------------------------------------------------
interface axi_slave_mem_if #(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_ID_WIDTH   = 3
);

   logic                      axi_slave_aw_valid;
   logic [AXI_ADDR_WIDTH-1:0] axi_slave_aw_addr;
   logic [AXI_ID_WIDTH-1:0]   axi_slave_aw_id;
   logic                      axi_slave_aw_ready;

   logic                      axi_slave_w_valid;
   logic [31:0]               axi_slave_w_data;
   logic [3:0]                axi_slave_w_strb;
   logic                      axi_slave_w_ready;

   logic                      axi_slave_b_valid;
   logic [1:0]                axi_slave_b_resp;
   logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id;
   logic                      axi_slave_b_ready;

   logic                      axi_slave_ar_valid;
   logic [AXI_ADDR_WIDTH-1:0] axi_slave_ar_addr;
   logic [AXI_ID_WIDTH-1:0]   axi_slave_ar_id;
   logic                      axi_slave_ar_ready;

   logic                      axi_slave_r_valid;
   logic [31:0]               axi_slave_r_data;
   logic [1:0]                axi_slave_r_resp;
   logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id;
   logic                      axi_slave_r_last;
   logic                      axi_slave_r_ready;

   modport slave (
      input  axi_slave_aw_valid, axi_slave_aw_addr, axi_slave_aw_id,
      output axi_slave_aw_ready,
      input  axi_slave_w_valid, axi_slave_w_data, axi_slave_w_strb,
      output axi_slave_w_ready,
      output axi_slave_b_valid, axi_slave_b_resp, axi_slave_b_id,
      input  axi_slave_b_ready,
      input  axi_slave_ar_valid, axi_slave_ar_addr, axi_slave_ar_id,
      output axi_slave_ar_ready,
      output axi_slave_r_valid, axi_slave_r_data, axi_slave_r_resp, axi_slave_r_id,
      output axi_slave_r_last,
      input  axi_slave_r_ready
   );

   modport master (
      output axi_slave_aw_valid, axi_slave_aw_addr, axi_slave_aw_id,
      input  axi_slave_aw_ready,
      output axi_slave_w_valid, axi_slave_w_data, axi_slave_w_strb,
      input  axi_slave_w_ready,
      input  axi_slave_b_valid, axi_slave_b_resp, axi_slave_b_id,
      output axi_slave_b_ready,
      output axi_slave_ar_valid, axi_slave_ar_addr, axi_slave_ar_id,
      input  axi_slave_ar_ready,
      input  axi_slave_r_valid, axi_slave_r_data, axi_slave_r_resp, axi_slave_r_id,
      input  axi_slave_r_last,
      output axi_slave_r_ready
   );

endinterface

// File: rtl/axi_slave_mem.sv
// -----------------------------------------------------------------------------
// axi_slave_mem
//   AXI4 single-beat slave that fronts a register-based memory of MEM_WORDS
//   32-bit words, which starts at BASE_ADDR. The write and read paths run
//   independently of each other.
//   Ports:
//     axi_aclk    - clock; all state changes on its rising edge
//     axi_aresetn - asynchronous active-low reset; clears FSMs, outputs, memory
//     bus         - axi_slave_mem_if.slave (AW, W, B, AR, R channels)
//   Responses: OKAY 2'b00, SLVERR 2'b10 (unaligned), DECERR 2'b11 (outside
//   the window).
// -----------------------------------------------------------------------------
module axi_slave_mem #(
   parameter int unsigned               AXI_ADDR_WIDTH = 32,
   parameter int unsigned               AXI_DATA_WIDTH = 32,
   parameter int unsigned               AXI_ID_WIDTH   = 3,
   parameter int unsigned               MEM_WORDS      = 256,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
   input logic            axi_aclk,
   input logic            axi_aresetn,
   axi_slave_mem_if.slave bus
);

   localparam int unsigned     DW       = AXI_DATA_WIDTH;
   localparam int unsigned     StrbW    = DW / 8;
   localparam int unsigned     IdxW     = $clog2(MEM_WORDS);
   localparam longint unsigned MemBytes = 64'(MEM_WORDS) * 64'd4;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;
   localparam logic [1:0] RespDecErr = 2'b11;

   typedef enum logic [1:0] {WIdle, WHaveAw, WHaveW, WResp} w_state_e;
   typedef enum logic       {RIdle, RData} r_state_e;

   // DECERR takes priority over SLVERR. An address below BASE_ADDR wraps to a
   // large offset and therefore also decodes as DECERR.
   function automatic void decode(input  logic [AXI_ADDR_WIDTH-1:0] addr,
                                  output logic [1:0]                resp,
                                  output logic [IdxW-1:0]           idx);
      logic [AXI_ADDR_WIDTH-1:0] off;
      off = addr - BASE_ADDR;
      idx = off[IdxW+1:2];
      if (64'(off) >= MemBytes) begin
         resp = RespDecErr;
      end else if (off[1:0] != 2'b00) begin
         resp = RespSlvErr;
      end else begin
         resp = RespOkay;
      end
   endfunction

   w_state_e w_state_q, w_state_d;
   r_state_e r_state_q, r_state_d;

   logic [DW-1:0]             mem_q [MEM_WORDS];

   logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
   logic [AXI_ID_WIDTH-1:0]   aw_id_q;
   logic [DW-1:0]             w_data_q;
   logic [StrbW-1:0]          w_strb_q;
   logic [1:0]                b_resp_q;
   logic [AXI_ID_WIDTH-1:0]   b_id_q;

   logic [DW-1:0]             r_data_q;
   logic [1:0]                r_resp_q;
   logic [AXI_ID_WIDTH-1:0]   r_id_q;

   logic aw_ready, w_ready, ar_ready;
   logic aw_hs, w_hs, ar_hs;
   logic commit;

   // Write operands: use the held copy when that half arrived earlier.
   logic [AXI_ADDR_WIDTH-1:0] wr_addr;
   logic [AXI_ID_WIDTH-1:0]   wr_id;
   logic [DW-1:0]             wr_data;
   logic [StrbW-1:0]          wr_strb;
   logic [1:0]                wr_resp;
   logic [IdxW-1:0]           wr_idx;
   logic [1:0]                rd_resp;
   logic [IdxW-1:0]           rd_idx;

   // ---------------------------------------------------------------- write FSM
   always_comb begin
      w_state_d = w_state_q;
      commit    = 1'b0;
      aw_ready  = (w_state_q == WIdle) || (w_state_q == WHaveW);
      w_ready   = (w_state_q == WIdle) || (w_state_q == WHaveAw);
      aw_hs     = bus.axi_slave_aw_valid && aw_ready;
      w_hs      = bus.axi_slave_w_valid && w_ready;
      unique case (w_state_q)
         WIdle: begin
            if (aw_hs && w_hs) begin
               w_state_d = WResp;
               commit    = 1'b1;
            end else if (aw_hs) begin
               w_state_d = WHaveAw;
            end else if (w_hs) begin
               w_state_d = WHaveW;
            end
         end
         WHaveAw: begin
            if (w_hs) begin
               w_state_d = WResp;
               commit    = 1'b1;
            end
         end
         WHaveW: begin
            if (aw_hs) begin
               w_state_d = WResp;
               commit    = 1'b1;
            end
         end
         WResp: begin
            if (bus.axi_slave_b_ready) w_state_d = WIdle;
         end
         default: w_state_d = WIdle;
      endcase
   end

   always_comb begin
      wr_addr = (w_state_q == WHaveAw) ? aw_addr_q : bus.axi_slave_aw_addr;
      wr_id   = (w_state_q == WHaveAw) ? aw_id_q   : bus.axi_slave_aw_id;
      wr_data = (w_state_q == WHaveW)  ? w_data_q  : bus.axi_slave_w_data;
      wr_strb = (w_state_q == WHaveW)  ? w_strb_q  : bus.axi_slave_w_strb;
      decode(wr_addr, wr_resp, wr_idx);
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         w_state_q <= WIdle;
         aw_addr_q <= '0;
         aw_id_q   <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         b_resp_q  <= '0;
         b_id_q    <= '0;
      end else begin
         w_state_q <= w_state_d;
         if (aw_hs) begin
            aw_addr_q <= bus.axi_slave_aw_addr;
            aw_id_q   <= bus.axi_slave_aw_id;
         end
         if (w_hs) begin
            w_data_q <= bus.axi_slave_w_data;
            w_strb_q <= bus.axi_slave_w_strb;
         end
         if (commit) begin
            b_resp_q <= wr_resp;
            b_id_q   <= wr_id;
         end
      end
   end

   // ------------------------------------------------------------------- memory
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         for (int unsigned i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
      end else if (commit && (wr_resp == RespOkay)) begin
         for (int unsigned k = 0; k < StrbW; k++) begin
            if (wr_strb[k]) mem_q[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
         end
      end
   end

   // ----------------------------------------------------------------- read FSM
   always_comb begin
      r_state_d = r_state_q;
      ar_ready  = (r_state_q == RIdle);
      ar_hs     = bus.axi_slave_ar_valid && ar_ready;
      unique case (r_state_q)
         RIdle:   if (ar_hs) r_state_d = RData;
         RData:   if (bus.axi_slave_r_ready) r_state_d = RIdle;
         default: r_state_d = RIdle;
      endcase
      decode(bus.axi_slave_ar_addr, rd_resp, rd_idx);
   end

   // mem_q is sampled before this edge's write lands, so a same-edge write to
   // the same word is not seen by the read.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_state_q <= RIdle;
         r_data_q  <= '0;
         r_resp_q  <= '0;
         r_id_q    <= '0;
      end else begin
         r_state_q <= r_state_d;
         if (ar_hs) begin
            r_data_q <= (rd_resp == RespOkay) ? mem_q[rd_idx] : '0;
            r_resp_q <= rd_resp;
            r_id_q   <= bus.axi_slave_ar_id;
         end
      end
   end

   // ------------------------------------------------------------------ outputs
   assign bus.axi_slave_aw_ready = aw_ready;
   assign bus.axi_slave_w_ready  = w_ready;
   assign bus.axi_slave_b_valid  = (w_state_q == WResp);
   assign bus.axi_slave_b_resp   = b_resp_q;
   assign bus.axi_slave_b_id     = b_id_q;
   assign bus.axi_slave_ar_ready = ar_ready;
   assign bus.axi_slave_r_valid  = (r_state_q == RData);
   assign bus.axi_slave_r_data   = r_data_q;
   assign bus.axi_slave_r_resp   = r_resp_q;
   assign bus.axi_slave_r_id     = r_id_q;
   assign bus.axi_slave_r_last   = (r_state_q == RData);

endmodule
